// File: rtl/maxpool2x2_relu_stream.sv
// Streaming 2x2 stride-2 max-pool with ReLU over packed multi-channel conv beats.
// Even rows park their horizontal pair maxima in a half-row line buffer; odd rows finish the window.
module maxpool2x2_relu_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int CH_WIDTH   = 2*(2*DATA_WIDTH+6)+6,
  parameter int NUM_CH     = 3,
  parameter int IN_WIDTH   = 220,
  parameter int IN_HEIGHT  = 220
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH*CH_WIDTH-1:0] conv_in,
  input  logic                       conv_in_valid,
  output logic [NUM_CH*CH_WIDTH-1:0] pool_out,
  output logic                       pool_out_valid,
  output logic                       pool_out_last
);

  localparam int PW    = NUM_CH*CH_WIDTH;
  localparam int OUT_W = IN_WIDTH/2;
  localparam int OUT_H = IN_HEIGHT/2;
  localparam int COL_W = $clog2(IN_WIDTH);
  localparam int ROW_W = $clog2(IN_HEIGHT);
  localparam int LB_AW = (OUT_W > 1) ? $clog2(OUT_W) : 1;

  localparam logic [COL_W-1:0] COL_LAST     = COL_W'(IN_WIDTH-1);
  localparam logic [ROW_W-1:0] ROW_LAST     = ROW_W'(IN_HEIGHT-1);
  localparam logic [COL_W-1:0] COL_PAIR_END = COL_W'(2*OUT_W-1);
  localparam logic [ROW_W-1:0] ROW_PAIR_END = ROW_W'(2*OUT_H-1);
  localparam bit               COL_ODD      = (IN_WIDTH % 2) == 1;
  localparam bit               ROW_ODD      = (IN_HEIGHT % 2) == 1;

  function automatic logic [CH_WIDTH-1:0] smax(input logic [CH_WIDTH-1:0] a,
                                                input logic [CH_WIDTH-1:0] b);
    if ($signed(a) > $signed(b)) begin
      return a;
    end else begin
      return b;
    end
  endfunction

  function automatic logic [CH_WIDTH-1:0] relu(input logic [CH_WIDTH-1:0] x);
    if (x[CH_WIDTH-1]) begin
      return {CH_WIDTH{1'b0}};
    end else begin
      return x;
    end
  endfunction

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [PW-1:0]    h_reg_q, h_reg_d;
  logic [PW-1:0]    pool_out_q, pool_out_d;
  logic             pool_out_valid_q, pool_out_valid_d;
  logic             pool_out_last_q, pool_out_last_d;

  logic [PW-1:0]    line_buf [0:OUT_W-1];
  logic [LB_AW-1:0] lb_idx_s;
  logic [PW-1:0]    lb_rdata_s;
  logic             lb_we_s;
  logic [PW-1:0]    h_s;
  logic [PW-1:0]    win_s;
  logic             col_in_s;
  logic             row_in_s;

  // Counters, horizontal max, window max and output decode.
  always_comb begin
    col_d            = col_q;
    row_d            = row_q;
    h_reg_d          = h_reg_q;
    pool_out_d       = pool_out_q;
    pool_out_valid_d = 1'b0;
    pool_out_last_d  = 1'b0;
    lb_we_s          = 1'b0;
    h_s              = {PW{1'b0}};
    win_s            = {PW{1'b0}};
    lb_idx_s         = LB_AW'(col_q >> 1);
    lb_rdata_s       = line_buf[lb_idx_s];
    col_in_s         = !COL_ODD || (col_q != COL_LAST);
    row_in_s         = !ROW_ODD || (row_q != ROW_LAST);

    for (int f = 0; f < NUM_CH; f++) begin
      h_s[f*CH_WIDTH +: CH_WIDTH]   = smax(h_reg_q[f*CH_WIDTH +: CH_WIDTH],
                                           conv_in[f*CH_WIDTH +: CH_WIDTH]);
      win_s[f*CH_WIDTH +: CH_WIDTH] = relu(smax(lb_rdata_s[f*CH_WIDTH +: CH_WIDTH],
                                                h_s[f*CH_WIDTH +: CH_WIDTH]));
    end

    if (conv_in_valid) begin
      if (col_q == COL_LAST) begin
        col_d = {COL_W{1'b0}};
        if (row_q == ROW_LAST) begin
          row_d = {ROW_W{1'b0}};
        end else begin
          row_d = row_q + ROW_W'(1);
        end
      end else begin
        col_d = col_q + COL_W'(1);
      end

      // Trailing odd column/row is counted but never stored or pooled.
      if (col_in_s && row_in_s) begin
        if (!col_q[0]) begin
          h_reg_d = conv_in;
        end else if (!row_q[0]) begin
          lb_we_s = 1'b1;
        end else begin
          pool_out_d       = win_s;
          pool_out_valid_d = 1'b1;
          pool_out_last_d  = (col_q == COL_PAIR_END) && (row_q == ROW_PAIR_END);
        end
      end else begin
        h_reg_d = h_reg_q;
      end
    end else begin
      col_d = col_q;
    end
  end

  // Line buffer has no reset: each entry is rewritten on an even row before the odd row reads it.
  always_ff @(posedge clk) begin
    if (lb_we_s) begin
      line_buf[lb_idx_s] <= h_s;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q            <= {COL_W{1'b0}};
      row_q            <= {ROW_W{1'b0}};
      h_reg_q          <= {PW{1'b0}};
      pool_out_q       <= {PW{1'b0}};
      pool_out_valid_q <= 1'b0;
      pool_out_last_q  <= 1'b0;
    end else begin
      col_q            <= col_d;
      row_q            <= row_d;
      h_reg_q          <= h_reg_d;
      pool_out_q       <= pool_out_d;
      pool_out_valid_q <= pool_out_valid_d;
      pool_out_last_q  <= pool_out_last_d;
    end
  end

  assign pool_out       = pool_out_q;
  assign pool_out_valid = pool_out_valid_q;
  assign pool_out_last  = pool_out_last_q;

endmodule

// File: tb/tb_maxpool2x2_relu_stream.sv
// Randomized bench for maxpool2x2_relu_stream: a 4x4 and a 5x5 instance checked every cycle
// against a window-level pooling model, plus literal expectations for the directed frames.
module tb_maxpool2x2_relu_stream;
  localparam int CW = 50;
  localparam int NC = 3;
  localparam int PW = NC*CW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [PW-1:0] in4 = '0, in5 = '0;
  logic          v4 = 1'b0, v5 = 1'b0;
  logic [PW-1:0] out4, out5;
  logic          ov4, ov5, ol4, ol5;

  int total = 0, bad = 0, cyc = 0, drv_cyc = 0;
  int W[2] = '{4, 5};
  int H[2] = '{4, 5};
  int mrow[2] = '{0, 0};
  int mcol[2] = '{0, 0};
  longint pix[2][5][5][NC];
  logic [PW-1:0] exp_data[int];
  bit            exp_last[int];
  logic [PW-1:0] hold[2] = '{default: '0};

  typedef struct {longint c0; longint c2; bit last; int cyc;} cap_t;
  cap_t cap0[$];
  cap_t cap1[$];

  maxpool2x2_relu_stream #(.IN_WIDTH(4), .IN_HEIGHT(4)) u4 (
    .clk(clk), .rst(rst), .conv_in(in4), .conv_in_valid(v4),
    .pool_out(out4), .pool_out_valid(ov4), .pool_out_last(ol4));

  maxpool2x2_relu_stream #(.IN_WIDTH(5), .IN_HEIGHT(5)) u5 (
    .clk(clk), .rst(rst), .conv_in(in5), .conv_in_valid(v5),
    .pool_out(out5), .pool_out_valid(ov5), .pool_out_last(ol5));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic longint ch_of(input logic [PW-1:0] x, input int ch);
    logic signed [CW-1:0] s;
    s = x[ch*CW +: CW];
    return longint'(s);
  endfunction

  // Model: remember every pixel of the frame; when a 2x2 window completes, its pooled beat is due next cycle.
  function automatic void model(input int d, input logic [PW-1:0] data);
    int r, c;
    logic [PW-1:0] e;
    longint m;
    r = mrow[d];
    c = mcol[d];
    for (int ch = 0; ch < NC; ch++) pix[d][r][c][ch] = ch_of(data, ch);
    if (r % 2 == 1 && c % 2 == 1 && r < 2*(H[d]/2) && c < 2*(W[d]/2)) begin
      e = '0;
      for (int ch = 0; ch < NC; ch++) begin
        m = pix[d][r][c][ch];
        for (int dr = 0; dr < 2; dr++)
          for (int dc = 0; dc < 2; dc++)
            if (pix[d][r-dr][c-dc][ch] > m) m = pix[d][r-dr][c-dc][ch];
        if (m < 0) m = 0;
        e[ch*CW +: CW] = m[CW-1:0];
      end
      exp_data[(cyc+1)*2+d] = e;
      exp_last[(cyc+1)*2+d] = (r == 2*(H[d]/2)-1) && (c == 2*(W[d]/2)-1);
    end
    mcol[d]++;
    if (mcol[d] == W[d]) begin
      mcol[d] = 0;
      mrow[d]++;
      if (mrow[d] == H[d]) mrow[d] = 0;
    end
  endfunction

  // Compare process: every cycle, both instances against the model.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic [PW-1:0] o, ed;
      logic ov, ol, ev, el;
      int k;
      cap_t cp;
      o  = (d == 0) ? out4 : out5;
      ov = (d == 0) ? ov4 : ov5;
      ol = (d == 0) ? ol4 : ol5;
      k  = cyc*2 + d;
      if (!rst) begin
        ev = 1'b0; el = 1'b0; ed = '0; hold[d] = '0;
      end else if (exp_data.exists(k)) begin
        ev = 1'b1; el = exp_last[k]; ed = exp_data[k]; hold[d] = ed;
        exp_data.delete(k);
        exp_last.delete(k);
      end else begin
        ev = 1'b0; el = 1'b0; ed = hold[d];
      end
      total++;
      if (ov !== ev || ol !== el || o !== ed) begin
        bad++;
        $display("FAIL cycle_check dut%0d cyc %0d: got valid=%0b last=%0b data=%h, want valid=%0b last=%0b data=%h",
                 d, cyc, ov, ol, o, ev, el, ed);
      end
      if (ov === 1'b1) begin
        cp.c0 = ch_of(o, 0); cp.c2 = ch_of(o, 2); cp.last = ol; cp.cyc = cyc;
        if (d == 0) cap0.push_back(cp);
        else cap1.push_back(cp);
      end
    end
  end

  task automatic chk(input string name, input longint act, input longint want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, want);
    end
  endtask

  task automatic step(input int d, input bit v, input logic [PW-1:0] data);
    @(posedge clk);
    #1;
    v4 = 1'b0;
    v5 = 1'b0;
    if (v) begin
      drv_cyc = cyc;
      if (d == 0) begin in4 = data; v4 = 1'b1; end
      else begin in5 = data; v5 = 1'b1; end
      model(d, data);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 1'b0, '0);
  endtask

  // kind: 0 ramp, 1 all -3 with (1,1)=-1, 2 all -3 with (1,1)=+9, 3 random
  function automatic logic [PW-1:0] gen(input int d, input int kind, input int r, input int c);
    logic [PW-1:0] x;
    longint v;
    for (int ch = 0; ch < NC; ch++) begin
      case (kind)
        0: v = (d == 0) ? 16*ch + r*4 + c : r*5 + c;
        1: v = (r == 1 && c == 1) ? -1 : -3;
        2: v = (r == 1 && c == 1) ? 9 : -3;
        default: begin
          if ($urandom_range(0, 1) == 1) v = {$urandom(), $urandom()};
          else v = longint'($urandom_range(0, 20)) - 10;
        end
      endcase
      x[ch*CW +: CW] = v[CW-1:0];
    end
    return x;
  endfunction

  task automatic send_frame(input int d, input int kind, input int maxgap, output int t0);
    t0 = 0;
    for (int r = 0; r < H[d]; r++)
      for (int c = 0; c < W[d]; c++) begin
        step(d, 1'b1, gen(d, kind, r, c));
        if (r == 0 && c == 0) t0 = drv_cyc;
        if (maxgap > 0) idle($urandom_range(0, maxgap));
      end
  endtask

  task automatic check_ramp4(input string tag, input int base);
    int e0[4] = '{5, 7, 13, 15};
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_ch0"}, cap0[base+i].c0, e0[i]);
      chk({tag, "_ch2"}, cap0[base+i].c2, e0[i] + 32);
      chk({tag, "_last"}, cap0[base+i].last, (i == 3) ? 1 : 0);
    end
  endtask

  initial begin
    int t0;
    int lat[4] = '{6, 8, 14, 16};
    int e5[4]  = '{6, 8, 16, 18};

    #2 rst = 1'b0;
    #1;
    chk("reset_data", out4 == '0 && out5 == '0, 1);
    chk("reset_valid", ov4 | ov5, 0);
    chk("reset_last", ol4 | ol5, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    cap0.delete();
    send_frame(0, 0, 0, t0);
    idle(3);
    chk("ramp_count", cap0.size(), 4);
    if (cap0.size() == 4) begin
      check_ramp4("ramp", 0);
      for (int i = 0; i < 4; i++) chk("ramp_latency", cap0[i].cyc - t0, lat[i]);
    end

    cap0.delete();
    send_frame(0, 1, 0, t0);
    idle(3);
    chk("relu_neg_count", cap0.size(), 4);
    if (cap0.size() == 4) begin
      chk("relu_neg_w0_ch0", cap0[0].c0, 0);
      chk("relu_neg_w0_ch2", cap0[0].c2, 0);
    end
    cap0.delete();
    send_frame(0, 2, 0, t0);
    idle(3);
    chk("relu_pos_count", cap0.size(), 4);
    if (cap0.size() == 4) begin
      chk("relu_pos_w0", cap0[0].c0, 9);
      chk("relu_pos_w1", cap0[1].c0, 0);
      chk("relu_pos_w3", cap0[3].c2, 0);
    end

    cap0.delete();
    send_frame(0, 0, 5, t0);
    idle(3);
    chk("gap_count", cap0.size(), 4);
    if (cap0.size() == 4) check_ramp4("gap", 0);

    cap1.delete();
    send_frame(1, 0, 0, t0);
    idle(3);
    chk("odd_count", cap1.size(), 4);
    if (cap1.size() == 4)
      for (int i = 0; i < 4; i++) begin
        chk("odd_val", cap1[i].c0, e5[i]);
        chk("odd_last", cap1[i].last, (i == 3) ? 1 : 0);
      end
    cap1.delete();
    send_frame(1, 3, 2, t0);
    idle(3);
    chk("odd_next_count", cap1.size(), 4);

    for (int i = 0; i < 6; i++) step(0, 1'b1, gen(0, 0, i/4, i%4));
    @(posedge clk);
    #1;
    v4 = 1'b0;
    rst = 1'b0;
    #1;
    chk("midreset_data", out4 == '0, 1);
    chk("midreset_valid", ov4, 0);
    mrow = '{0, 0};
    mcol = '{0, 0};
    exp_data.delete();
    exp_last.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    cap0.delete();
    send_frame(0, 0, 0, t0);
    idle(3);
    chk("after_reset_count", cap0.size(), 4);
    if (cap0.size() == 4) check_ramp4("after_reset", 0);

    cap0.delete();
    send_frame(0, 0, 0, t0);
    send_frame(0, 0, 0, t0);
    idle(3);
    chk("b2b_count", cap0.size(), 8);
    if (cap0.size() == 8) begin
      check_ramp4("b2b_f1", 0);
      check_ramp4("b2b_f2", 4);
    end

    for (int i = 0; i < 6; i++) begin
      send_frame(0, 3, $urandom_range(0, 2), t0);
      send_frame(1, 3, 1, t0);
    end
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
